// File: rtl/line_window3x3_if.sv
// Pixel-stream input and registered 3x3 window output bundle for line_window3x3.
interface line_window3x3_if;
    logic       in_valid;
    logic       in_sof;
    logic [7:0] in_pix;
    logic [7:0] p0, p1, p2;
    logic [7:0] p3, p4, p5;
    logic [7:0] p6, p7, p8;
    logic       out_valid;

    modport master (
        output in_valid, in_sof, in_pix,
        input  p0, p1, p2, p3, p4, p5, p6, p7, p8, out_valid
    );

    modport slave (
        input  in_valid, in_sof, in_pix,
        output p0, p1, p2, p3, p4, p5, p6, p7, p8, out_valid
    );
endinterface

// File: rtl/line_window3x3.sv
// Streaming 3x3 neighbourhood generator: two line buffers feed a 3x3 shift window;
// out_valid flags only fully populated interior windows.
module line_window3x3 #(
    parameter int unsigned WIDTH = 640
) (
    input logic             clk,
    input logic             rst,
    line_window3x3_if.slave bus
);
    localparam int unsigned ColW = $clog2(WIDTH);
    localparam logic [ColW-1:0] ColLast = ColW'(WIDTH - 1);
    localparam logic [ColW-1:0] ColFirstValid = ColW'(2);

    typedef enum logic [1:0] {StRow0, StRow1, StStream} line_state_e;

    line_state_e     state_q;
    line_state_e     state_eff;
    logic [ColW-1:0] col_q;
    logic [ColW-1:0] col_eff;
    logic [7:0]      lb0 [WIDTH];
    logic [7:0]      lb1 [WIDTH];
    logic [7:0]      lb0_rd;
    logic [7:0]      lb1_rd;
    logic [7:0]      win_q [9];
    logic            out_valid_q;
    logic            accept;

    assign accept = bus.in_valid & ~rst;

    // A start-of-frame pixel is (0,0) wherever the counters happen to be.
    assign col_eff   = bus.in_sof ? '0 : col_q;
    assign state_eff = bus.in_sof ? StRow0 : state_q;

    assign lb0_rd = lb0[col_eff];
    assign lb1_rd = lb1[col_eff];

    // Buffer contents are never reset; the line FSM masks stale data.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col_eff] <= lb0_rd;
            lb0[col_eff] <= bus.in_pix;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRow0;
            col_q       <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= '0;
            end
        end else if (bus.in_valid) begin
            out_valid_q <= (state_eff == StStream) && (col_eff >= ColFirstValid);
            for (int r = 0; r < 3; r++) begin
                win_q[3*r]   <= win_q[3*r+1];
                win_q[3*r+1] <= win_q[3*r+2];
            end
            win_q[2] <= lb1_rd;
            win_q[5] <= lb0_rd;
            win_q[8] <= bus.in_pix;
            if (col_eff == ColLast) begin
                col_q   <= '0;
                state_q <= (state_eff == StRow0) ? StRow1 : StStream;
            end else begin
                col_q   <= col_eff + ColW'(1);
                state_q <= state_eff;
            end
        end else begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.p0        = win_q[0];
    assign bus.p1        = win_q[1];
    assign bus.p2        = win_q[2];
    assign bus.p3        = win_q[3];
    assign bus.p4        = win_q[4];
    assign bus.p5        = win_q[5];
    assign bus.p6        = win_q[6];
    assign bus.p7        = win_q[7];
    assign bus.p8        = win_q[8];
    assign bus.out_valid = out_valid_q;
endmodule

// File: doc/line_window3x3.md
# line_window3x3

Streaming 3x3 neighbourhood generator placed directly upstream of the Roberts edge operator. It accepts one 8-bit pixel per valid cycle in raster order, keeps the two previous image lines in internal line buffers, and presents a registered 3x3 window on p0..p8 (row-major, p4 = centre) with a valid strobe. Only fully populated interior windows are flagged valid; there is no border padding.

## Interface
- WIDTH, 640: pixels per image line; legal range 3..4096.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  in_pix is accepted on every clk edge where in_valid=1.
- in_sof  in  1  qualified by in_valid; marks the accepted pixel as (row 0, col 0) of a new frame.
- in_pix  in  8  input pixel.
- p0,p1,p2  out  8 each  window top row, left to right (oldest line).
- p3,p4,p5  out  8 each  window middle row; p4 is the centre pixel.
- p6,p7,p8  out  8 each  window bottom row (current line); p8 is the newest pixel.
- out_valid  out  1  one-cycle strobe; p0..p8 hold a complete interior window.

## Operation
- Counters: col (0..WIDTH-1, wraps) and line state FSM: ROW0 -> ROW1 -> STREAM.
- Accepted pixel with col=WIDTH-1: col <= 0; FSM advances ROW0->ROW1->STREAM; STREAM holds.
- Accepted pixel with in_sof=1: treated as (0,0) regardless of current col/state; after it col=1, FSM=ROW0. Any partial line/frame is abandoned.
- Line buffers lb0 (previous line) and lb1 (line before that), WIDTH x 8 each. On accepted pixel at address col: read old lb0[col], lb1[col]; write lb1[col] <= old lb0[col], lb0[col] <= in_pix (read-before-write, same cycle).
- Window register array 3x3: on accepted pixel, shift left by one column; new right column = {p2 <= old lb1[col], p5 <= old lb0[col], p8 <= in_pix}.
- out_valid <= 1 on the edge after an accepted pixel iff FSM=STREAM (at acceptance) and col >= 2; window centre is then (row-1, col-1). Otherwise out_valid <= 0.
- in_valid=0: window registers, counters, buffers hold; out_valid <= 0.
- Windows straddling a line wrap (col 0,1) contain stale columns; never flagged valid.
- Per frame of H lines: exactly (WIDTH-2)*(H-2) valid strobes.
- Reset: p0..p8 = 0, out_valid = 0, col = 0, FSM = ROW0. Line-buffer contents not reset (masked by FSM). rst has priority over a simultaneous in_valid; that pixel is discarded.
- No back-pressure: downstream must accept every strobe.

## Timing
- Latency: pixel accepted at edge N appears on p8 after edge N; out_valid high in cycle N..N+1, one cycle wide.
- Throughput: one window per clk at continuous in_valid.
- Roberts stage downstream adds its own pipeline; this block adds exactly 1 cycle.
- All outputs registered; no combinational path from inputs to outputs.
- Line buffer read is same-cycle (distributed or write-first-bypassed RAM must present OLD data).

## Test plan
- WIDTH=4, continuous in_valid, in_sof on first pixel, pixel value = 4*row+col, 3 lines -> exactly 2 strobes; first after pixel 10: p0..p8 = 0,1,2,4,5,6,8,9,10; second = 1,2,3,5,6,7,9,10,11.
- Same stream with in_valid deasserted for 3 cycles every other pixel -> identical window sequence, strobes only on cycle after accepted pixel, outputs stable during gaps.
- WIDTH=4, 5 lines -> 6 strobes; line 4 col 2 window = 8,9,10,12,13,14,16,17,18; no strobe at cols 0,1 of any line.
- in_sof reasserted at row 2 col 1 (value 100 onward) -> no strobe until two further full lines plus col 2; first window rows built solely from new-frame pixels.
- rst pulsed mid-line 3 with in_valid=1 -> that pixel dropped, all p* = 0, out_valid = 0 next cycle; restart frame reproduces scenario 1 values.
- WIDTH=640 random frame 640x480 vs software 3x3 model -> 638*478 strobes, all windows match.
